join_any_apb_slave: RTL and testbench



---
 rtl/join_any_apb_slave.sv | 122 ++++++++++++
 tb/tb_join_any_apb_slave.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/join_any_apb_slave.sv
// APB3 slave with a word-addressed register file; out-of-range accesses return PSLVERR.
// Latency: 2 + WAIT_STATES cycles per transfer (SETUP + ACCESS); read data is registered at the end of SETUP.
// Backpressure: PREADY is held low for WAIT_STATES ACCESS cycles; back-to-back transfers run at full rate.
module join_any_apb_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          WS_L    = 4'(WAIT_STATES);

    logic [1:0]            state_q, state_d;
    logic [1:0]            phase;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  err;
    logic                  ready;
    logic                  wr_en;
    logic                  rd_load;

    assign idx   = PADDR[IDX_W-1:0];
    assign err   = ({1'b0, PADDR} >= DEPTH_L);
    assign ready = (state_q == ACCESS) && (cnt_q == WS_L);
    assign wr_en = PSEL && PENABLE && ready && PWRITE && !err;

    // Current bus phase. The master opens SETUP in the same cycle it raises PSEL,
    // so SETUP is decoded from the bus; only ACCESS needs to be remembered.
    always_comb begin
        phase = IDLE;
        if (state_q == ACCESS) begin
            phase = ACCESS;
        end else if (PSEL && !PENABLE) begin
            phase = SETUP;
        end
    end

    // Next state and wait counter: SETUP always moves to ACCESS, ACCESS stalls until
    // the counter reaches WAIT_STATES; a back-to-back SETUP is picked up by the decode above.
    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        case (phase)
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = 4'd0;
            end
            ACCESS: begin
                if (ready) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Read data is captured at the SETUP->ACCESS edge so it is valid in the first ACCESS cycle.
    assign rd_load = (phase == SETUP) && !PWRITE;

    // Read data mux: out-of-range reads return zero, otherwise the stored word; writes leave it alone.
    always_comb begin
        prdata_d = prdata_q;
        if (rd_load) begin
            prdata_d = err ? '0 : mem_q[idx];
        end
    end

    // FSM, wait counter and read-data register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prdata_q <= prdata_d;
        end
    end

    // Register file: committed on the completing ACCESS edge of an in-range write.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= PWDATA;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = ready;
    assign PSLVERR = ready && err;

endmodule

// File: tb/tb_join_any_apb_slave.sv
module tb_join_any_apb_slave;

    logic        PCLK;
    logic        PRESETn;
    logic [2:0]  psel;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int vectors;
    int miscompares;

    // Reference model: one word array per instance, plus the last value read.
    logic [31:0] mdl     [3][64];
    logic [31:0] last_rd [3];
    int          ws      [3];

    initial begin
        ws[0] = 0;
        ws[1] = 3;
        ws[2] = 2;
    end

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    join_any_apb_slave #(.WAIT_STATES(0)) u_ws0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
    join_any_apb_slave #(.WAIT_STATES(3)) u_ws3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
    join_any_apb_slave #(.WAIT_STATES(2)) u_ws2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            last_rd[k] = 32'h0;
            for (int a = 0; a < 64; a++) mdl[k][a] = 32'h0;
        end
    endtask

    // Model of a completed transfer: returns expected read data and error.
    task automatic model_xfer(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                              output logic [31:0] exp_rd, output logic exp_err);
        exp_err = (a >= 8'd64);
        exp_rd  = last_rd[k];
        if (wr) begin
            if (!exp_err) mdl[k][a[5:0]] = d;
        end else begin
            exp_rd     = exp_err ? 32'h0 : mdl[k][a[5:0]];
            last_rd[k] = exp_rd;
        end
    endtask

    // One APB transfer on instance k, entered and left just after a rising edge.
    // Reports PRDATA/PSLVERR in the completing cycle, total cycle count, and whether
    // PSLVERR was ever seen high while PREADY was low.
    task automatic apb_xfer(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err, output int cyc, output bit bad_err);
        bit done;
        psel     = 3'b000;
        psel[k]  = 1'b1;
        PENABLE  = 1'b0;
        PWRITE   = wr;
        PADDR    = a;
        PWDATA   = d;
        rd       = 32'hx;
        err      = 1'bx;
        bad_err  = 1'b0;
        done     = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        cyc     = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            cyc++;
            @(negedge PCLK);
            if (pready[k]) begin
                rd   = prdata[k];
                err  = pslverr[k];
                done = 1'b1;
            end else if (pslverr[k]) begin
                bad_err = 1'b1;
            end
            @(posedge PCLK); #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL pready_timeout inst%0d addr %h: PREADY never rose, required within %0d cycles", k, a, 2 + ws[k]);
        end
    endtask

    task automatic bus_idle(input int n);
        psel    = 3'b000;
        PENABLE = 1'b0;
        repeat (n) begin
            @(posedge PCLK); #1;
        end
    endtask

    // Transfer plus full check against the model.
    task automatic xfer_chk(input string nm, input int k, input bit wr, input logic [7:0] a, input logic [31:0] d);
        logic [31:0] rd, exp_rd;
        logic        err, exp_err;
        int          cyc;
        bit          bad;
        apb_xfer(k, wr, a, d, rd, err, cyc, bad);
        model_xfer(k, wr, a, d, exp_rd, exp_err);
        vectors++;
        if (rd !== exp_rd) begin
            miscompares++;
            $display("FAIL %s prdata inst%0d addr %h: got %h required %h", nm, k, a, rd, exp_rd);
        end
        vectors++;
        if (err !== exp_err) begin
            miscompares++;
            $display("FAIL %s pslverr inst%0d addr %h: got %b required %b", nm, k, a, err, exp_err);
        end
        vectors++;
        if (cyc != 2 + ws[k]) begin
            miscompares++;
            $display("FAIL %s cycles inst%0d addr %h: got %0d required %0d", nm, k, a, cyc, 2 + ws[k]);
        end
        vectors++;
        if (bad !== 1'b0) begin
            miscompares++;
            $display("FAIL %s early_pslverr inst%0d addr %h: got 1 required 0", nm, k, a);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (prdata[k] !== 32'h0) begin
                miscompares++;
                $display("FAIL %s prdata inst%0d: got %h required 00000000", nm, k, prdata[k]);
            end
            vectors++;
            if (pready[k] !== 1'b0 || pslverr[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s ready/err inst%0d: got %b/%b required 0/0", nm, k, pready[k], pslverr[k]);
            end
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        psel    = 3'b000;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = 8'h0;
        PWDATA  = 32'h0;
        model_reset();
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check_idle_outputs("reset");
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic test_basic();
        xfer_chk("basic_wr05", 0, 1'b1, 8'h05, 32'hDEADBEEF);
        xfer_chk("basic_wr3f", 0, 1'b1, 8'h3F, 32'h12345678);
        bus_idle(1);
        xfer_chk("basic_rd05", 0, 1'b0, 8'h05, 32'h0);
        xfer_chk("basic_rd3f", 0, 1'b0, 8'h3F, 32'h0);
        bus_idle(1);
    endtask

    task automatic test_unwritten();
        xfer_chk("unwritten_rd10", 0, 1'b0, 8'h10, 32'h0);
        bus_idle(1);
    endtask

    task automatic test_error();
        xfer_chk("err_wr40", 0, 1'b1, 8'h40, 32'hA5A5A5A5);
        xfer_chk("err_rd40", 0, 1'b0, 8'h40, 32'h0);
        xfer_chk("err_rd00", 0, 1'b0, 8'h00, 32'h0);
        xfer_chk("err_rdff", 0, 1'b0, 8'hFF, 32'h0);
        bus_idle(1);
    endtask

    task automatic test_wait_states();
        xfer_chk("wait_wr02", 1, 1'b1, 8'h02, 32'h0BADCAFE);
        xfer_chk("wait_rd02", 1, 1'b0, 8'h02, 32'h0);
        xfer_chk("wait_err", 1, 1'b0, 8'h50, 32'h0);
        bus_idle(1);
    endtask

    task automatic test_back_to_back();
        xfer_chk("b2b_wr01", 0, 1'b1, 8'h01, 32'h00000011);
        xfer_chk("b2b_rd01", 0, 1'b0, 8'h01, 32'h0);
        xfer_chk("b2b_wr02", 2, 1'b1, 8'h02, 32'h00000022);
        xfer_chk("b2b_rd02", 2, 1'b0, 8'h02, 32'h0);
        bus_idle(1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            int          k;
            bit          wr;
            logic [7:0]  a;
            logic [31:0] d;
            k  = int'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 79));
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 3));
            d  = $urandom;
            xfer_chk("random", k, wr, a, d);
            if ($urandom_range(0, 2) == 0) bus_idle(1);
        end
        bus_idle(1);
    endtask

    task automatic test_reset_mid();
        xfer_chk("mid_wr03", 2, 1'b1, 8'h03, 32'hCAFEF00D);
        xfer_chk("mid_rd03", 2, 1'b0, 8'h03, 32'h0);
        xfer_chk("mid_wr09", 0, 1'b1, 8'h09, 32'h99999999);
        // Write to addr 7 on the 2-wait-state instance, reset during its first ACCESS cycle.
        psel    = 3'b100;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 8'h07;
        PWDATA  = 32'h77777777;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        model_reset();
        check_idle_outputs("mid_reset");
        psel    = 3'b000;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer_chk("mid_rd07", 2, 1'b0, 8'h07, 32'h0);
        xfer_chk("mid_rd09", 0, 1'b0, 8'h09, 32'h0);
        bus_idle(1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_unwritten();
        test_error();
        test_wait_states();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

endmodule
